// File: rtl/input_array_mux_reg.sv
// Purpose : registered row selector feeding the HEVC sub-pixel vertical FIR (integer window or a/b/c half arrays).
// Latency : one clock from sel/array inputs to mux.
// Backpressure: none; a new selection is accepted every cycle.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset (clears mux)
//   integer_array       15 rows x 15 pixels, row r at [r*120 +: 120], pixel p at [+p*8 +: 8]
//   a/b/c_half_array    8 rows x 15 pixels each, same packing
//   sel                 0..14 integer row, 15..22 a row, 23..30 b row, 31..38 c row, else zero
//   mux                 registered selected row, pixel p at [p*8 +: 8]
//   mux_valid           (only with INPUT_ARRAY_MUX_VALID_EN) 1 when the sampled sel was in 0..38
module input_array_mux_reg #(
  parameter int PIX_W     = 8,
  parameter int ROW_PIX   = 15,
  parameter int INT_ROWS  = 15,
  parameter int HALF_ROWS = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [INT_ROWS*ROW_PIX*PIX_W-1:0]  integer_array,
  input  logic [HALF_ROWS*ROW_PIX*PIX_W-1:0] a_half_array,
  input  logic [HALF_ROWS*ROW_PIX*PIX_W-1:0] b_half_array,
  input  logic [HALF_ROWS*ROW_PIX*PIX_W-1:0] c_half_array,
  input  logic [7:0]                         sel,
  output logic [ROW_PIX*PIX_W-1:0]           mux
`ifdef INPUT_ARRAY_MUX_VALID_EN
  ,
  output logic                               mux_valid
`endif
);

  localparam int ROW_W  = ROW_PIX * PIX_W;
  // First select code of each half-sample array; codes at or beyond SEL_END map to zero.
  localparam int A_BASE  = INT_ROWS;
  localparam int B_BASE  = A_BASE + HALF_ROWS;
  localparam int C_BASE  = B_BASE + HALF_ROWS;
  localparam int SEL_END = C_BASE + HALF_ROWS;

  logic [ROW_W-1:0] mux_d;

  // Each code matches at most one row, so a flat compare-per-row OR-less priority
  // chain is equivalent to a one-hot mux; unmatched codes keep the zero default.
  always_comb begin
    mux_d = '0;
    for (int r = 0; r < INT_ROWS; r++) begin
      if (sel == 8'(r)) mux_d = integer_array[r*ROW_W +: ROW_W];
    end
    for (int m = 0; m < HALF_ROWS; m++) begin
      if (sel == 8'(A_BASE + m)) mux_d = a_half_array[m*ROW_W +: ROW_W];
      if (sel == 8'(B_BASE + m)) mux_d = b_half_array[m*ROW_W +: ROW_W];
      if (sel == 8'(C_BASE + m)) mux_d = c_half_array[m*ROW_W +: ROW_W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mux <= '0;
    end else begin
      mux <= mux_d;
    end
  end

`ifdef INPUT_ARRAY_MUX_VALID_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      mux_valid <= 1'b0;
    end else begin
      mux_valid <= (sel < 8'(SEL_END));
    end
  end
`endif

endmodule

// File: tb/tb_input_array_mux_reg.sv
module tb_input_array_mux_reg;

  logic           clock = 1'b0;
  logic           reset;
  logic [1799:0]  integer_array;
  logic [959:0]   a_half_array;
  logic [959:0]   b_half_array;
  logic [959:0]   c_half_array;
  logic [7:0]     sel;
  logic [119:0]   mux;
`ifdef INPUT_ARRAY_MUX_VALID_EN
  logic           mux_valid;
`endif

  input_array_mux_reg dut (
    .clock         (clock),
    .reset         (reset),
    .integer_array (integer_array),
    .a_half_array  (a_half_array),
    .b_half_array  (b_half_array),
    .c_half_array  (c_half_array),
    .sel           (sel),
    .mux           (mux)
`ifdef INPUT_ARRAY_MUX_VALID_EN
    ,
    .mux_valid     (mux_valid)
`endif
  );

  always #5 clock = ~clock;

  // Pixel-level view of the sources; packed vectors are derived from these.
  logic [7:0] int_px [15][15];
  logic [7:0] a_px   [8][15];
  logic [7:0] b_px   [8][15];
  logic [7:0] c_px   [8][15];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [119:0] act, input logic [119:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic pack_all();
    for (int r = 0; r < 15; r++)
      for (int p = 0; p < 15; p++)
        integer_array[r*120 + p*8 +: 8] = int_px[r][p];
    for (int m = 0; m < 8; m++)
      for (int p = 0; p < 15; p++) begin
        a_half_array[m*120 + p*8 +: 8] = a_px[m][p];
        b_half_array[m*120 + p*8 +: 8] = b_px[m][p];
        c_half_array[m*120 + p*8 +: 8] = c_px[m][p];
      end
  endtask

  // Reference: pick the pixel row by code range, pixel by pixel.
  function automatic logic [119:0] model_row(input int s);
    logic [119:0] v;
    logic [7:0]   b;
    v = '0;
    for (int p = 0; p < 15; p++) begin
      b = 8'h00;
      if (s < 15)      b = int_px[s][p];
      else if (s < 23) b = a_px[s-15][p];
      else if (s < 31) b = b_px[s-23][p];
      else if (s < 39) b = c_px[s-31][p];
      v[p*8 +: 8] = b;
    end
    return v;
  endfunction

  logic [119:0] exp_mux;
  logic         exp_vld;
  logic         have_exp = 1'b0;

  always @(posedge clock) begin
    exp_mux  <= reset ? 120'd0 : model_row(int'(sel));
    exp_vld  <= !reset && (int'(sel) <= 38);
    have_exp <= 1'b1;
  end

  always @(negedge clock) begin
    if (have_exp) begin
      chk("cycle_mux", mux, exp_mux);
`ifdef INPUT_ARRAY_MUX_VALID_EN
      chk("cycle_valid", {119'd0, mux_valid}, {119'd0, exp_vld});
`endif
    end
  end

  task automatic step(input logic [7:0] s);
    sel = s;
    pack_all();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [119:0] ramp(input logic [7:0] base);
    logic [119:0] v;
    for (int p = 0; p < 15; p++) v[p*8 +: 8] = base + 8'(p);
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    sel   = 8'd7;
    for (int r = 0; r < 15; r++)
      for (int p = 0; p < 15; p++) int_px[r][p] = 8'($urandom);
    for (int m = 0; m < 8; m++)
      for (int p = 0; p < 15; p++) begin
        a_px[m][p] = 8'($urandom);
        b_px[m][p] = 8'($urandom);
        c_px[m][p] = 8'($urandom);
      end
    pack_all();

    // Reset held for two edges with an in-range select.
    step(8'd7);
    chk("reset_edge1", mux, 120'd0);
`ifdef INPUT_ARRAY_MUX_VALID_EN
    chk("reset_valid", {119'd0, mux_valid}, 120'd0);
`endif
    step(8'd20);
    chk("reset_edge2", mux, 120'd0);

    // Integer rows: pixel(r,p) = r*16 + p.
    for (int r = 0; r < 15; r++)
      for (int p = 0; p < 15; p++) int_px[r][p] = 8'(r*16 + p);
    for (int m = 0; m < 8; m++)
      for (int p = 0; p < 15; p++) begin
        a_px[m][p] = 8'(8'hA0 + m);
        b_px[m][p] = 8'(8'hB0 + m);
        c_px[m][p] = 8'(8'hC0 + m);
      end
    reset = 1'b0;
    step(8'd0);  chk("int_row0",  mux, ramp(8'h00));
    step(8'd1);  chk("int_row1",  mux, ramp(8'h10));
    step(8'd2);  chk("int_row2",  mux, ramp(8'h20));
    step(8'd14); chk("int_row14", mux, ramp(8'hE0));
    chk("int_row14_lit", mux, 120'hEEEDECEBEAE9E8E7E6E5E4E3E2E1E0);

    // Half-sample rows.
    step(8'd15); chk("a_row0", mux, {15{8'hA0}});
    step(8'd16); chk("a_row1", mux, {15{8'hA1}});
    step(8'd22); chk("a_row7", mux, {15{8'hA7}});
    step(8'd23); chk("b_row0", mux, {15{8'hB0}});
    step(8'd30); chk("b_row7", mux, {15{8'hB7}});
    step(8'd31); chk("c_row0", mux, {15{8'hC0}});
    step(8'd38); chk("c_row7", mux, {15{8'hC7}});
`ifdef INPUT_ARRAY_MUX_VALID_EN
    chk("valid_38", {119'd0, mux_valid}, {119'd0, 1'b1});
`endif

    // Out-of-range codes.
    step(8'd39);  chk("oor_39",  mux, 120'd0);
`ifdef INPUT_ARRAY_MUX_VALID_EN
    chk("valid_39", {119'd0, mux_valid}, 120'd0);
`endif
    step(8'd200); chk("oor_200", mux, 120'd0);
    step(8'd255); chk("oor_255", mux, 120'd0);
    step(8'd0);   chk("back_row0", mux, ramp(8'h00));

    // Mid-stream reset.
    step(8'd5);   chk("row5", mux, ramp(8'h50));
    reset = 1'b1;
    step(8'd5);   chk("mid_reset", mux, 120'd0);
    reset = 1'b0;
    step(8'd5);   chk("row5_again", mux, ramp(8'h50));

    // Data tracking on the selected row only.
    step(8'd3);   chk("row3", mux, ramp(8'h30));
    for (int p = 0; p < 15; p++) int_px[3][p] = 8'hFF;
    step(8'd3);   chk("row3_ff", mux, {15{8'hFF}});
    for (int p = 0; p < 15; p++) int_px[4][p] = 8'h55;
    for (int p = 0; p < 15; p++) a_px[0][p] = 8'h12;
    step(8'd3);   chk("row3_stable", mux, {15{8'hFF}});
    step(8'd4);   chk("row4_new", mux, {15{8'h55}});
    step(8'd15);  chk("a_row0_new", mux, {15{8'h12}});

    // Back-to-back sweep over every code, checked by the per-cycle model.
    for (int s = 0; s < 256; s++) step(8'(s));
    step(8'd0);

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
